mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares a single-ported unified instruction/data memory between the fetch stage and the load/store unit.
- Arbitrates requests with a fixed priority plus a starvation guard.
- Holds the granted request stable until the memory accepts it.
- Tracks outstanding transactions so each read response returns to the requester that issued it.
- Sits between the core's fetch/memory stages and the SoC memory port; a fetch request that is not granted drives fetch stall upstream.

Parameters:
- MAX_OUTST, 2, maximum accepted-but-unanswered memory transactions (1..4).
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch takes priority (>=1).

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  32  fetch address
- if_gnt_o  out  1  fetch request accepted by memory this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- lsu_req_i  in  1  LSU request
- lsu_we_i  in  1  LSU write enable
- lsu_be_i  in  4  LSU byte enables
- lsu_addr_i  in  32  LSU address
- lsu_wdata_i  in  32  LSU write data
- lsu_gnt_o  out  1  LSU request accepted
- lsu_rvalid_o  out  1  LSU response valid (read data, or write ack)
- lsu_rdata_o  out  32  LSU read data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables (4'hF for fetch)
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  memory response (one per accepted request, writes included, in order)
- mem_rdata_i  in  32  memory read data
- spurious_o  out  1  pulse: mem_rvalid_i seen with no outstanding transaction

Behaviour:
- **Reset** (async, rst_ni low):
  - Clears owner FIFO, count, lock, starvation counter and spurious_o.
  - mem_req_o, if_gnt_o, lsu_gnt_o, if_rvalid_o and lsu_rvalid_o are forced 0 while in reset.
  - rdata outputs pass mem_rdata_i (don't care).
- **Arbitration** (combinational, same cycle as the request), applied when lock = 0 and count < MAX_OUTST:
  - LSU wins if lsu_req_i, unless starve_cnt == STARVE_LIMIT and if_req_i, in which case fetch wins.
  - Otherwise fetch wins if if_req_i.
- **Request muxing:**
  - mem_req_o = a winner exists.
  - mem_* fields are muxed from the winner.
  - For a fetch win: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
- **Lock:**
  - If mem_req_o && !mem_gnt_i, register lock = 1 and lock_owner = winner.
  - While locked, lock_owner is presented regardless of priority or starvation, and count is not checked.
  - Lock clears on mem_gnt_i.
  - Requesters hold req and address/data stable until their gnt; a dropped req while locked drops mem_req_o (protocol error, not guarded).
- **Grants:** if_gnt_o / lsu_gnt_o = mem_req_o && mem_gnt_i && owner matches.
- **Owner FIFO** (depth MAX_OUTST, 1-bit entry: 0 = fetch, 1 = LSU):
  - Push on any gnt.
  - Pop on mem_rvalid_i when count > 0.
  - Simultaneous push/pop keeps count unchanged.
  - New arbitration is blocked when count == MAX_OUTST, even if a pop occurs that cycle.
  - Zero-latency responses are not allowed: a response no earlier than the cycle after gnt is guaranteed by the memory.
- **Response routing:** if_rvalid_o / lsu_rvalid_o = mem_rvalid_i && count > 0 && head owner matches.
- **Spurious response:** mem_rvalid_i with count == 0 routes to neither requester; spurious_o = 1 the next cycle (registered, one cycle).
- **Starvation counter** (saturating at STARVE_LIMIT):
  - Increments each cycle if_req_i && !if_gnt_o.
  - Clears on if_gnt_o, or when if_req_i is low.
- **Reset mid-transaction:** responses arriving after reset release are treated as spurious.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- **Defined:** adds outputs perf_if_stall_o[31:0] and perf_lsu_stall_o[31:0].
  - Each counts cycles its requester's req is high with no gnt.
  - Wrap at 2^32.
  - Reset to 0 asynchronously.
- **Undefined:** ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- **Single fetch:** if_req_i=1, addr 0x100, mem_gnt_i=1 immediately, rvalid one cycle later with rdata 0xDEADBEEF -> if_gnt_o=1 cycle 0, mem_be_o=4'hF, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF cycle 1, lsu_rvalid_o=0.
- **Collision:** if_req_i and lsu_req_i (write, addr 0x200, be 4'h3) in the same cycle -> LSU granted first with mem_we_o=1, mem_be_o=4'h3; fetch granted the next cycle; responses are routed LSU then fetch.
- **Starvation:** lsu_req_i held high continuously, if_req_i high, STARVE_LIMIT=4 -> fetch denied 4 cycles, granted on the 5th; starvation counter then clears and LSU wins again.
- **Lock:** LSU wins, mem_gnt_i held low 3 cycles while if_req_i rises and starve_cnt reaches its limit -> mem_addr_o stays the LSU address for all cycles until gnt; no owner switch.
- **Outstanding limit:** MAX_OUTST=2, two grants with no rvalid -> mem_req_o=0 with a pending request; after one rvalid, the request issues the following cycle. Separately, an rvalid with an empty FIFO -> spurious_o pulses 1 cycle, no requester rvalid.
- **Reset mid-operation:** reset asserted with 1 outstanding fetch -> all outputs 0 immediately. With ARB_PERF_CNT_EN: perf_lsu_stall_o equals the count of denied LSU cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU: LSU priority, fetch starvation guard, in-order response routing. Optional ARB_PERF_CNT_EN adds stall counters.
// Latency: request/grant is combinational; responses are routed in the cycle mem_rvalid_i arrives.
// Backpressure: a denied requester stalls; a presented request is held until mem_gnt_i; new issue stops at MAX_OUTST outstanding.
module mem_port_arbiter #(
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        spurious_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_stall_o,
    output logic [31:0] perf_lsu_stall_o
`endif
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] OUTST_MAX  = CW'(MAX_OUTST);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [CW-1:0]        count_q, count_d, wr_idx;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 lock_q, lock_d;
    logic                 lock_owner_q, lock_owner_d;
    logic                 spurious_q, spurious_d;
    logic                 win_vld, win_lsu, push, pop;

    always_comb begin
        win_vld = 1'b0;
        win_lsu = 1'b0;
        if (lock_q) begin
            win_lsu = lock_owner_q;
            win_vld = lock_owner_q ? lsu_req_i : if_req_i;
        end else if (count_q < OUTST_MAX) begin
            if (lsu_req_i && !(if_req_i && starve_q == STARVE_MAX)) begin
                win_vld = 1'b1;
                win_lsu = 1'b1;
            end else if (if_req_i) begin
                win_vld = 1'b1;
            end
        end
    end

    assign mem_req_o   = rst_ni & win_vld;
    assign mem_we_o    = win_lsu & lsu_we_i;
    assign mem_be_o    = win_lsu ? lsu_be_i : 4'hF;
    assign mem_addr_o  = win_lsu ? lsu_addr_i : if_addr_i;
    assign mem_wdata_o = win_lsu ? lsu_wdata_i : 32'h0;

    assign push      = mem_req_o & mem_gnt_i;
    assign if_gnt_o  = push & ~win_lsu;
    assign lsu_gnt_o = push & win_lsu;

    // owner_q[0] is the oldest outstanding transaction
    assign pop          = mem_rvalid_i && (count_q != '0);
    assign if_rvalid_o  = rst_ni & pop & ~owner_q[0];
    assign lsu_rvalid_o = rst_ni & pop & owner_q[0];
    assign if_rdata_o   = mem_rdata_i;
    assign lsu_rdata_o  = mem_rdata_i;
    assign spurious_o   = spurious_q;

    always_comb begin
        owner_d = owner_q;
        count_d = count_q;
        wr_idx  = count_q;
        if (pop) begin
            owner_d = owner_q >> 1;
            count_d = count_q - CW'(1);
            wr_idx  = count_q - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (CW'(i) == wr_idx) owner_d[i] = win_lsu;
            end
            count_d = count_d + CW'(1);
        end
    end

    always_comb begin
        starve_d = '0;
        if (if_req_i && !if_gnt_o) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        end
        lock_d       = mem_req_o & ~mem_gnt_i;
        lock_owner_d = lock_d ? win_lsu : lock_owner_q;
        spurious_d   = mem_rvalid_i && (count_q == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q      <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            spurious_q   <= spurious_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_lsu_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_if_q  <= '0;
            perf_lsu_q <= '0;
        end else begin
            if (if_req_i && !if_gnt_o)   perf_if_q  <= perf_if_q + 32'd1;
            if (lsu_req_i && !lsu_gnt_o) perf_lsu_q <= perf_lsu_q + 32'd1;
        end
    end

    assign perf_if_stall_o  = perf_if_q;
    assign perf_lsu_stall_o = perf_lsu_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses, a negedge monitor pops and checks them.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i, lsu_req_i, lsu_we_i, mem_gnt_i;
    logic [31:0] if_addr_i, lsu_addr_i, lsu_wdata_i;
    logic [3:0]  lsu_be_i;
    logic        if_gnt_o, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] if_rdata_o, lsu_rdata_o;
    logic        mem_req_o, mem_we_o, spurious_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_o, perf_lsu_stall_o;
`endif

    // memory model: auto mode answers every grant one cycle later, otherwise force_* drive the response
    logic        auto_mode, auto_rv, force_rv, mdl_gnt;
    logic [31:0] auto_data, force_data, mdl_addr;
    assign mem_rvalid_i = auto_mode ? auto_rv : force_rv;
    assign mem_rdata_i  = auto_mode ? auto_data : force_data;

    typedef struct { bit lsu; logic [31:0] data; } exp_t;
    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .spurious_o(spurious_o)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall_o(perf_if_stall_o), .perf_lsu_stall_o(perf_lsu_stall_o)
`endif
    );

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ~a;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic expect_rsp(input bit lsu, input logic [31:0] a);
        exp_t e;
        e.lsu  = lsu;
        e.data = fdata(a);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always begin
        @(negedge clk_i);
        mdl_gnt  = mem_req_o && mem_gnt_i;
        mdl_addr = mem_addr_o;
        @(posedge clk_i);
        #1;
        auto_rv   = mdl_gnt;
        auto_data = fdata(mdl_addr);
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && (if_rvalid_o || lsu_rvalid_o)) begin
            chk1("rsp_both", if_rvalid_o & lsu_rvalid_o, 1'b0);
            if (exp_q.size() == 0) begin
                chk32("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk1("rsp_owner", lsu_rvalid_o, e.lsu);
                chk32("rsp_data", lsu_rvalid_o ? lsu_rdata_o : if_rdata_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; auto_mode = 1'b1; auto_rv = 1'b0; auto_data = '0;
        force_rv = 1'b0; force_data = '0;
        if_req_i = 1'b1; if_addr_i = '0; lsu_req_i = 1'b1; lsu_we_i = 1'b0;
        lsu_be_i = 4'hF; lsu_addr_i = '0; lsu_wdata_i = '0; mem_gnt_i = 1'b1;
        #3;
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk1("rst_if_gnt", if_gnt_o, 1'b0);
        chk1("rst_lsu_gnt", lsu_gnt_o, 1'b0);
        chk1("rst_spurious", spurious_o, 1'b0);
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;

        // single fetch
        if_req_i = 1'b1; if_addr_i = 32'h100;
        @(negedge clk_i);
        chk1("f1_if_gnt", if_gnt_o, 1'b1);
        chk1("f1_lsu_gnt", lsu_gnt_o, 1'b0);
        chk32("f1_addr", mem_addr_o, 32'h100);
        chk32("f1_be", {28'd0, mem_be_o}, 32'hF);
        expect_rsp(1'b0, 32'h100);
        tick();
        if_req_i = 1'b0;
        @(negedge clk_i);
        chk1("f1_if_rvalid", if_rvalid_o, 1'b1);
        chk32("f1_if_rdata", if_rdata_o, 32'hDEADBEEF);
        chk1("f1_lsu_rvalid", lsu_rvalid_o, 1'b0);
        tick();

        // collision: LSU write first, fetch next cycle
        if_req_i = 1'b1; if_addr_i = 32'h104;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'h3;
        lsu_addr_i = 32'h200; lsu_wdata_i = 32'h12345678;
        @(negedge clk_i);
        chk1("col_lsu_gnt", lsu_gnt_o, 1'b1);
        chk1("col_if_gnt0", if_gnt_o, 1'b0);
        chk1("col_we", mem_we_o, 1'b1);
        chk32("col_be", {28'd0, mem_be_o}, 32'h3);
        chk32("col_addr", mem_addr_o, 32'h200);
        chk32("col_wdata", mem_wdata_o, 32'h12345678);
        expect_rsp(1'b1, 32'h200);
        tick();
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = 4'hF;
        @(negedge clk_i);
        chk1("col_if_gnt1", if_gnt_o, 1'b1);
        chk32("col_if_addr", mem_addr_o, 32'h104);
        chk1("col_fetch_we", mem_we_o, 1'b0);
        chk32("col_fetch_wdata", mem_wdata_o, 32'h0);
        expect_rsp(1'b0, 32'h104);
        tick();
        if_req_i = 1'b0;
        repeat (3) tick();

        // starvation: fetch wins on the 5th contended cycle, then LSU again
        lsu_req_i = 1'b1; lsu_addr_i = 32'h300;
        if_req_i = 1'b1; if_addr_i = 32'h108;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            chk1($sformatf("starve_if_gnt%0d", k), if_gnt_o, k == 4);
            chk1($sformatf("starve_lsu_gnt%0d", k), lsu_gnt_o, k != 4);
            if (k == 4) expect_rsp(1'b0, 32'h108);
            else        expect_rsp(1'b1, 32'h300);
            tick();
            if (k == 4) if_addr_i = 32'h10C;
        end
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        repeat (3) tick();

        // lock: LSU held through stalls even once fetch reaches the starvation limit
        lsu_req_i = 1'b1; lsu_addr_i = 32'h400;
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin
                if_req_i = 1'b1; if_addr_i = 32'h110;
            end
            mem_gnt_i = (k == 6);
            @(negedge clk_i);
            chk1($sformatf("lock_req%0d", k), mem_req_o, 1'b1);
            chk32($sformatf("lock_addr%0d", k), mem_addr_o, 32'h400);
            chk1($sformatf("lock_lsu_gnt%0d", k), lsu_gnt_o, k == 6);
            chk1($sformatf("lock_if_gnt%0d", k), if_gnt_o, 1'b0);
            if (k == 6) expect_rsp(1'b1, 32'h400);
            tick();
        end
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk1("lock_after_if_gnt", if_gnt_o, 1'b1);
        chk32("lock_after_addr", mem_addr_o, 32'h110);
        expect_rsp(1'b0, 32'h110);
        tick();
        if_req_i = 1'b0;
        repeat (3) tick();

        // outstanding limit with manually driven responses
        auto_mode = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h120;
        @(negedge clk_i);
        chk1("ost_gnt0", if_gnt_o, 1'b1);
        expect_rsp(1'b0, 32'h120);
        tick();
        if_addr_i = 32'h124;
        @(negedge clk_i);
        chk1("ost_gnt1", if_gnt_o, 1'b1);
        expect_rsp(1'b0, 32'h124);
        tick();
        if_req_i = 1'b0; lsu_req_i = 1'b1; lsu_addr_i = 32'h500;
        @(negedge clk_i);
        chk1("ost_full_req", mem_req_o, 1'b0);
        chk1("ost_full_gnt", lsu_gnt_o, 1'b0);
        tick();
        force_rv = 1'b1; force_data = fdata(32'h120);
        @(negedge clk_i);
        chk1("ost_pop_blocked", mem_req_o, 1'b0);
        tick();
        force_rv = 1'b0;
        @(negedge clk_i);
        chk1("ost_reissue", lsu_gnt_o, 1'b1);
        expect_rsp(1'b1, 32'h500);
        tick();
        lsu_req_i = 1'b0; force_rv = 1'b1; force_data = fdata(32'h124);
        tick();
        force_data = fdata(32'h500);
        tick();
        force_rv = 1'b0;
        tick();

        // spurious response with an empty owner FIFO
        force_rv = 1'b1; force_data = 32'hBAD0BAD0;
        @(negedge clk_i);
        chk1("sp_if_rvalid", if_rvalid_o, 1'b0);
        chk1("sp_lsu_rvalid", lsu_rvalid_o, 1'b0);
        chk1("sp_pre", spurious_o, 1'b0);
        tick();
        force_rv = 1'b0;
        @(negedge clk_i);
        chk1("sp_pulse", spurious_o, 1'b1);
        tick();
        @(negedge clk_i);
        chk1("sp_clear", spurious_o, 1'b0);
        tick();

        // reset with one fetch outstanding; its late response becomes spurious
        if_req_i = 1'b1; if_addr_i = 32'h130;
        @(negedge clk_i);
        chk1("rm_if_gnt", if_gnt_o, 1'b1);
        tick();
        rst_ni = 1'b0; lsu_req_i = 1'b1; force_rv = 1'b1;
        #1;
        chk1("rm_mem_req", mem_req_o, 1'b0);
        chk1("rm_if_gnt0", if_gnt_o, 1'b0);
        chk1("rm_lsu_gnt0", lsu_gnt_o, 1'b0);
        chk1("rm_if_rvalid", if_rvalid_o, 1'b0);
        chk1("rm_lsu_rvalid", lsu_rvalid_o, 1'b0);
        tick();
        rst_ni = 1'b1; if_req_i = 1'b0; lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk1("rm_late_if_rvalid", if_rvalid_o, 1'b0);
        chk1("rm_late_lsu_rvalid", lsu_rvalid_o, 1'b0);
        tick();
        force_rv = 1'b0;
        @(negedge clk_i);
        chk1("rm_spurious", spurious_o, 1'b1);
        tick();

        // three denied LSU cycles before a grant
        auto_mode = 1'b1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h600; mem_gnt_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk1("pf_denied", lsu_gnt_o, 1'b0);
            tick();
        end
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        chk1("pf_gnt", lsu_gnt_o, 1'b1);
        expect_rsp(1'b1, 32'h600);
        tick();
        lsu_req_i = 1'b0; lsu_we_i = 1'b0;
`ifdef ARB_PERF_CNT_EN
        @(negedge clk_i);
        chk32("perf_lsu", perf_lsu_stall_o, 32'd3);
        chk32("perf_if", perf_if_stall_o, 32'd0);
`endif
        repeat (4) tick();
        chk32("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
